// File: rtl/ysyx_23060208_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060208_pc_ctrl
// Function : Instruction-fetch PC controller. Issues one read per PC on an
//            AXI-lite style read channel and hands each fetched word to decode
//            through a valid/ready pair, with branch/trap redirect support.
// Revision : 1.0  initial release
// ============================================================================
module ysyx_23060208_pc_ctrl #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(32'h2000_0000)
) (
    input  logic                  clock,
    input  logic                  reset,
    // read address channel
    output logic                  arvalid,
    output logic [DATA_WIDTH-1:0] araddr,
    input  logic                  arready,
    // read data channel
    input  logic                  rvalid,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    output logic                  rready,
    // decode handoff
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [DATA_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready,
    // control flow
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  fetch_err,
    output logic [DATA_WIDTH-1:0] pc
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_HOLD = 3'd3,
        ST_HALT = 3'd4
    } state_e;

    state_e                  state_q;
    logic [DATA_WIDTH-1:0]   pc_q;
    logic [DATA_WIDTH-1:0]   pending_q;
    logic [DATA_WIDTH-1:0]   inst_q;
    logic [DATA_WIDTH-1:0]   inst_pc_q;
    logic                    flush_q;
    logic                    arvalid_q;
    logic                    rready_q;
    logic                    inst_valid_q;
    logic                    fetch_err_q;

    logic [DATA_WIDTH-1:0]   w_redir_tgt;
    logic [DATA_WIDTH-1:0]   w_pc_seq;

    // All PCs are word aligned, so the two low bits of a redirect are dropped.
    assign w_redir_tgt = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
    assign w_pc_seq    = pc_q + DATA_WIDTH'(4);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            pending_q    <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            flush_q      <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            inst_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            fetch_err_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (redirect_valid) begin
                        pc_q <= w_redir_tgt;
                    end
                    arvalid_q <= 1'b1;
                    state_q   <= ST_ADDR;
                end

                ST_ADDR: begin
                    // The address already on the bus stays put; the redirect
                    // is remembered and applied once its data returns.
                    if (redirect_valid) begin
                        flush_q   <= 1'b1;
                        pending_q <= w_redir_tgt;
                    end
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (rvalid) begin
                        rready_q <= 1'b0;
                        if (redirect_valid || flush_q) begin
                            pc_q      <= redirect_valid ? w_redir_tgt : pending_q;
                            flush_q   <= 1'b0;
                            arvalid_q <= 1'b1;
                            state_q   <= ST_ADDR;
                        end else if (rresp == 2'b00) begin
                            inst_q       <= rdata;
                            inst_pc_q    <= pc_q;
                            inst_valid_q <= 1'b1;
                            state_q      <= ST_HOLD;
                        end else begin
                            fetch_err_q <= 1'b1;
                            state_q     <= ST_HALT;
                        end
                    end else if (redirect_valid) begin
                        flush_q   <= 1'b1;
                        pending_q <= w_redir_tgt;
                    end
                end

                ST_HOLD: begin
                    // A redirect takes priority over a simultaneous consume.
                    if (redirect_valid || inst_ready) begin
                        pc_q         <= redirect_valid ? w_redir_tgt : w_pc_seq;
                        inst_valid_q <= 1'b0;
                        arvalid_q    <= 1'b1;
                        state_q      <= ST_ADDR;
                    end
                end

                ST_HALT: begin
                    state_q <= ST_HALT;
                end

                default: begin
                    arvalid_q    <= 1'b0;
                    rready_q     <= 1'b0;
                    inst_valid_q <= 1'b0;
                    flush_q      <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign arvalid    = arvalid_q;
    assign araddr     = pc_q;
    assign rready     = rready_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign fetch_err  = fetch_err_q;
    assign pc         = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060208_pc_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ysyx_23060208_pc_ctrl
// Function : Self-checking bench for the fetch PC controller.
// Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_23060208_pc_ctrl;
    localparam logic [31:0] RST_PC = 32'h2000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        arvalid, arready, rvalid, rready, inst_valid, inst_ready;
    logic        redirect_valid, fetch_err;
    logic [31:0] araddr, rdata, inst, inst_pc, redirect_pc, pc;
    logic [1:0]  rresp;

    always #5 clock = ~clock;

    ysyx_23060208_pc_ctrl #(.DATA_WIDTH(32), .RESET_PC(RST_PC)) dut (
        .clock(clock), .reset(reset),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_err(fetch_err), .pc(pc)
    );

    int checks = 0;
    int errors = 0;

    // memory responder state
    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_lat, mem_lat_cfg;
    bit          mem_lat_rand, err_en, force_en;
    logic [31:0] err_addr, force_data;

    // outputs seen just before the most recent edge
    logic        p_arvalid, p_rready, p_inst_valid;
    logic [31:0] p_araddr, p_inst, p_inst_pc;

    // reference model: PC the next delivered instruction must carry
    logic [31:0] exp_next;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        mem_busy = 1'b0; mem_lat = 0; mem_lat_cfg = 0; mem_lat_rand = 1'b0;
        err_en = 1'b0; force_en = 1'b0;
        @(posedge clock); #2;
        reset = 1'b0;
        exp_next = RST_PC;
    endtask

    // One clock: present memory response, step the edge, update memory + model.
    task automatic cycle();
        if (mem_busy && mem_lat == 0) begin
            rvalid = 1'b1;
            rdata  = force_en ? force_data : mem_word(mem_addr);
            rresp  = (err_en && mem_addr == err_addr) ? 2'b10 : 2'b00;
        end else begin
            rvalid = 1'b0;
            rdata  = $urandom;
            rresp  = 2'b00;
        end
        p_arvalid = arvalid; p_araddr = araddr; p_rready = rready;
        p_inst_valid = inst_valid; p_inst = inst; p_inst_pc = inst_pc;
        @(posedge clock); #1;
        if (mem_busy) begin
            if (rvalid && p_rready) mem_busy = 1'b0;
            else if (mem_lat > 0) mem_lat = mem_lat - 1;
        end else if (p_arvalid && arready) begin
            mem_busy = 1'b1;
            mem_addr = p_araddr;
            mem_lat  = mem_lat_rand ? int'($urandom_range(0, 3)) : mem_lat_cfg;
        end
        if (redirect_valid) exp_next = {redirect_pc[31:2], 2'b00};
        else if (p_inst_valid && inst_ready) exp_next = exp_next + 32'd4;
    endtask

    task automatic test_reset();
        reset = 1'b1; rvalid = 1'b1; arready = 1'b1; inst_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
        repeat (2) @(posedge clock);
        #1;
        checks++; if ({arvalid, rready, inst_valid, fetch_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_handshake: got %b expected 0000", {arvalid, rready, inst_valid, fetch_err}); end
        checks++; if (pc !== RST_PC) begin
            errors++; $display("FAIL reset_pc: got %h expected %h", pc, RST_PC); end
        checks++; if (araddr !== RST_PC) begin
            errors++; $display("FAIL reset_araddr: got %h expected %h", araddr, RST_PC); end
        checks++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin
            errors++; $display("FAIL reset_inst: got %h/%h expected 0/0", inst, inst_pc); end
    endtask

    task automatic test_sequential();
        bit          e_av, e_iv;
        logic [31:0] e_a;
        do_reset();
        arready = 1'b1; inst_ready = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            cycle();
            e_av = (n % 3 == 1);
            e_iv = (n % 3 == 0);
            checks++; if (arvalid !== e_av) begin
                errors++; $display("FAIL seq_arvalid c%0d: got %b expected %b", n, arvalid, e_av); end
            checks++; if (inst_valid !== e_iv) begin
                errors++; $display("FAIL seq_inst_valid c%0d: got %b expected %b", n, inst_valid, e_iv); end
            if (e_av) begin
                e_a = RST_PC + 32'(4 * ((n - 1) / 3));
                checks++; if (araddr !== e_a) begin
                    errors++; $display("FAIL seq_araddr c%0d: got %h expected %h", n, araddr, e_a); end
            end
            if (e_iv) begin
                e_a = RST_PC + 32'(4 * (n / 3 - 1));
                checks++; if (inst_pc !== e_a || inst !== mem_word(e_a)) begin
                    errors++; $display("FAIL seq_inst c%0d: got %h@%h expected %h@%h", n, inst, inst_pc, mem_word(e_a), e_a); end
            end
        end
    endtask

    task automatic test_addr_stall();
        do_reset();
        inst_ready = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            arready = 1'b0;
            cycle();
            checks++; if (arvalid !== 1'b1 || araddr !== RST_PC || rready !== 1'b0) begin
                errors++; $display("FAIL stall_addr c%0d: got av=%b a=%h rr=%b expected 1 %h 0", n, arvalid, araddr, rready, RST_PC); end
        end
        arready = 1'b1;
        cycle();
        checks++; if (arvalid !== 1'b0 || rready !== 1'b1) begin
            errors++; $display("FAIL stall_release: got av=%b rr=%b expected 0 1", arvalid, rready); end
    endtask

    task automatic test_redirect_data();
        do_reset();
        arready = 1'b1; inst_ready = 1'b1; mem_lat_cfg = 2;
        force_en = 1'b1; force_data = 32'h0000_0013;
        repeat (2) cycle();
        checks++; if (rready !== 1'b1) begin
            errors++; $display("FAIL rdata_in_data: got rready=%b expected 1", rready); end
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0003;
        cycle();
        redirect_valid = 1'b0;
        for (int n = 0; n < 2; n++) begin
            if (n == 1) mem_lat_cfg = 0;
            cycle();
            checks++; if (inst_valid !== 1'b0 || fetch_err !== 1'b0) begin
                errors++; $display("FAIL rdata_discard c%0d: got iv=%b fe=%b expected 0 0", n, inst_valid, fetch_err); end
        end
        force_en = 1'b0;
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0000) begin
            errors++; $display("FAIL rdata_new_addr: got av=%b a=%h expected 1 80000000", arvalid, araddr); end
        repeat (2) cycle();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0000 || inst !== mem_word(32'h8000_0000)) begin
            errors++; $display("FAIL rdata_next_inst: got iv=%b %h@%h expected 1 %h@80000000", inst_valid, inst, inst_pc, mem_word(32'h8000_0000)); end
    endtask

    task automatic test_redirect_hold();
        do_reset();
        arready = 1'b1; inst_ready = 1'b0;
        repeat (3) cycle();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== RST_PC) begin
            errors++; $display("FAIL hold_present: got iv=%b pc=%h expected 1 %h", inst_valid, inst_pc, RST_PC); end
        cycle();
        checks++; if (inst_valid !== 1'b1 || inst !== p_inst || inst_pc !== p_inst_pc) begin
            errors++; $display("FAIL hold_stable: got iv=%b %h@%h expected 1 %h@%h", inst_valid, inst, inst_pc, p_inst, p_inst_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h2000_0100;
        cycle();
        redirect_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0 || arvalid !== 1'b1 || araddr !== 32'h2000_0100) begin
            errors++; $display("FAIL hold_redirect: got iv=%b av=%b a=%h expected 0 1 20000100", inst_valid, arvalid, araddr); end
    endtask

    task automatic test_fetch_err();
        do_reset();
        arready = 1'b1; inst_ready = 1'b1;
        err_en = 1'b1; err_addr = 32'h2000_0004;
        for (int n = 1; n <= 25; n++) begin
            if (n >= 7) begin
                redirect_valid = 1'($urandom_range(0, 1));
                redirect_pc = $urandom;
            end
            cycle();
            checks++; if (fetch_err !== (n == 6)) begin
                errors++; $display("FAIL err_pulse c%0d: got %b expected %b", n, fetch_err, (n == 6)); end
            if (n >= 6) begin
                checks++; if ({arvalid, rready, inst_valid} !== 3'b000 || pc !== 32'h2000_0004) begin
                    errors++; $display("FAIL err_halt c%0d: got av/rr/iv=%b pc=%h expected 000 20000004", n, {arvalid, rready, inst_valid}, pc); end
            end
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_wrap_reset();
        do_reset();
        arready = 1'b1; inst_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        cycle();
        redirect_valid = 1'b0;
        checks++; if (arvalid !== 1'b1 || araddr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_idle_redirect: got av=%b a=%h expected 1 fffffffc", arvalid, araddr); end
        repeat (2) cycle();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst !== mem_word(32'hFFFF_FFFC)) begin
            errors++; $display("FAIL wrap_inst: got iv=%b %h@%h expected 1 %h@fffffffc", inst_valid, inst, inst_pc, mem_word(32'hFFFF_FFFC)); end
        cycle();
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h0000_0000) begin
            errors++; $display("FAIL wrap_addr: got av=%b a=%h expected 1 00000000", arvalid, araddr); end
        cycle();
        checks++; if (rready !== 1'b1) begin
            errors++; $display("FAIL wrap_in_data: got rready=%b expected 1", rready); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({arvalid, rready, inst_valid, fetch_err} !== 4'b0000 || pc !== RST_PC || inst !== 32'h0 || inst_pc !== 32'h0) begin
            errors++; $display("FAIL async_reset: got hs=%b pc=%h inst=%h ipc=%h expected 0000 %h 0 0",
                               {arvalid, rready, inst_valid, fetch_err}, pc, inst, inst_pc, RST_PC); end
        mem_busy = 1'b0;
        rvalid = 1'b1; rdata = 32'h0000_0013; rresp = 2'b00;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        checks++; if (rready !== 1'b0 || inst_valid !== 1'b0 || arvalid !== 1'b1 || araddr !== RST_PC) begin
            errors++; $display("FAIL post_reset_rvalid: got rr=%b iv=%b av=%b a=%h expected 0 0 1 %h", rready, inst_valid, arvalid, araddr, RST_PC); end
        rvalid = 1'b0;
    endtask

    task automatic test_random();
        int delivered = 0;
        do_reset();
        mem_lat_rand = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            arready        = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = $urandom;
            cycle();
            if (inst_valid && !p_inst_valid) begin
                delivered++;
                checks++; if (inst_pc !== exp_next) begin
                    errors++; $display("FAIL rnd_inst_pc c%0d: got %h expected %h", n, inst_pc, exp_next); end
                checks++; if (inst !== mem_word(exp_next)) begin
                    errors++; $display("FAIL rnd_inst c%0d: got %h expected %h", n, inst, mem_word(exp_next)); end
            end
            if (inst_valid && p_inst_valid) begin
                checks++; if (inst !== p_inst || inst_pc !== p_inst_pc) begin
                    errors++; $display("FAIL rnd_hold_stable c%0d: got %h@%h expected %h@%h", n, inst, inst_pc, p_inst, p_inst_pc); end
            end
            if (p_arvalid && !arready) begin
                checks++; if (arvalid !== 1'b1 || araddr !== p_araddr) begin
                    errors++; $display("FAIL rnd_addr_stable c%0d: got av=%b a=%h expected 1 %h", n, arvalid, araddr, p_araddr); end
            end
            checks++; if ((arvalid && rready) || fetch_err !== 1'b0) begin
                errors++; $display("FAIL rnd_protocol c%0d: got av=%b rr=%b fe=%b expected no overlap, fe=0", n, arvalid, rready, fetch_err); end
        end
        checks++; if (delivered < 100) begin
            errors++; $display("FAIL rnd_progress: got %0d deliveries expected at least 100", delivered); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_addr_stall();
        test_redirect_data();
        test_redirect_hold();
        test_fetch_err();
        test_wrap_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
